ex_div: RTL

- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits in the EX stage and consumes operands and rd address that the ID/EX pipeline register delivers.
- Stretches EX over many cycles by requesting a pipeline hold through busy_o, then returns the result and rd address to EX writeback with a one-cycle ready_o pulse.

---
 rtl/ex_div_pkg.sv | 25 ++
 rtl/ex_div.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ex_div_pkg.sv
// ============================================================================
// Module      : ex_div_pkg
// Description : Shared funct3 codes, divider state encoding and constants.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package ex_div_pkg;

    localparam logic [2:0] INST_DIV  = 3'b100;
    localparam logic [2:0] INST_DIVU = 3'b101;
    localparam logic [2:0] INST_REM  = 3'b110;
    localparam logic [2:0] INST_REMU = 3'b111;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_CALC = 2'b01,
        DIV_END  = 2'b10
    } div_state_t;

endpackage

`default_nettype wire

// File: rtl/ex_div.sv
// ============================================================================
// Module      : ex_div
// Description : Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//               Optional macro DIV_EARLY_OUT_EN skips the iterations for
//               divide-by-zero and unsigned dividend < divisor.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ex_div
    import ex_div_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic [4:0]      reg_waddr_i,
    input  logic            flush_i,
    output logic [XLEN-1:0] result_o,
    output logic            ready_o,
    output logic            busy_o,
    output logic [4:0]      reg_waddr_o
);

    div_state_t r_state;
    div_state_t w_next_state;

    logic [CNT_W-1:0] r_count;
    logic [2:0]       r_op;
    logic [4:0]       r_rd;
    logic [XLEN-1:0]  r_dividend;
    logic [XLEN-1:0]  r_divisor;
    logic [XLEN-1:0]  r_rem;
    logic [XLEN-1:0]  r_quot;
    logic             r_negate_q;
    logic             r_negate_r;
    logic             r_zero_div;

    logic             w_signed_op;
    logic [XLEN-1:0]  w_dividend_abs;
    logic [XLEN-1:0]  w_divisor_abs;
    logic             w_accept;
    logic             w_last;
    logic             w_early;
    logic [XLEN:0]    w_shift_rem;
    logic             w_ge;
    logic [XLEN-1:0]  w_diff;
    logic [XLEN-1:0]  w_sel;

    // funct3[0] clear means a signed operation (DIV/REM)
    assign w_signed_op    = ~op_i[0];
    assign w_dividend_abs = (w_signed_op & dividend_i[XLEN-1]) ? -dividend_i : dividend_i;
    assign w_divisor_abs  = (w_signed_op & divisor_i[XLEN-1])  ? -divisor_i  : divisor_i;

    assign w_accept = (r_state == DIV_IDLE) & start_i & ~flush_i;
    assign w_last   = (r_count == CNT_W'(XLEN - 1));

`ifdef DIV_EARLY_OUT_EN
    assign w_early = r_zero_div | (r_op[0] & (r_dividend < r_divisor));
`else
    assign w_early = 1'b0;
`endif

    // Shifted partial remainder needs one extra bit before the trial subtract
    assign w_shift_rem = {r_rem, r_quot[XLEN-1]};
    assign w_ge        = (w_shift_rem >= {1'b0, r_divisor});
    assign w_diff      = w_shift_rem[XLEN-1:0] - r_divisor;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        busy_o       = 1'b0;
        case (r_state)
            DIV_IDLE: begin
                if (w_accept) begin
                    w_next_state = DIV_CALC;
                    busy_o       = 1'b1;
                end
            end
            DIV_CALC: begin
                busy_o = 1'b1;
                if (flush_i) begin
                    w_next_state = DIV_IDLE;
                end else if (w_early || w_last) begin
                    w_next_state = DIV_END;
                end
            end
            DIV_END: begin
                w_next_state = DIV_IDLE;
            end
            default: begin
                w_next_state = DIV_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count    <= '0;
            r_op       <= '0;
            r_rd       <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_quot     <= '0;
            r_negate_q <= 1'b0;
            r_negate_r <= 1'b0;
            r_zero_div <= 1'b0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (w_accept) begin
                        r_count    <= '0;
                        r_op       <= op_i;
                        r_rd       <= reg_waddr_i;
                        r_dividend <= dividend_i;
                        r_divisor  <= w_divisor_abs;
                        r_rem      <= '0;
                        r_quot     <= w_dividend_abs;
                        r_negate_q <= dividend_i[XLEN-1] ^ divisor_i[XLEN-1];
                        r_negate_r <= dividend_i[XLEN-1];
                        r_zero_div <= (divisor_i == '0);
                    end
                end
                DIV_CALC: begin
                    if (!flush_i) begin
                        if (w_early) begin
                            r_quot <= '0;
                            r_rem  <= r_dividend;
                        end else begin
                            r_rem   <= w_ge ? w_diff : w_shift_rem[XLEN-1:0];
                            r_quot  <= {r_quot[XLEN-2:0], w_ge};
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Divide-by-zero result overrides whatever the iterations produced
    always_comb begin
        w_sel = r_negate_q ? -r_quot : r_quot;
        case (r_op)
            INST_DIVU: w_sel = r_quot;
            INST_REMU: w_sel = r_rem;
            INST_REM:  w_sel = r_negate_r ? -r_rem : r_rem;
            default:   w_sel = r_negate_q ? -r_quot : r_quot;
        endcase
        if (r_zero_div) begin
            w_sel = r_op[1] ? r_dividend : ~ZERO_WORD;
        end
    end

    assign ready_o     = (r_state == DIV_END) & ~flush_i;
    assign result_o    = ready_o ? w_sel : ZERO_WORD;
    assign reg_waddr_o = ready_o ? r_rd : 5'd0;

endmodule

`default_nettype wire
